// File: rtl/grad_quant_ctx_if.sv
// Stream bundle for the gradient quantiser: gradient triplet in,
// folded quantised triplet with context index out.
interface grad_quant_ctx_if #(
    parameter int DW = 8
);
    logic              in_valid;
    logic              in_ready;
    logic signed [DW:0] d1;
    logic signed [DW:0] d2;
    logic signed [DW:0] d3;
    logic              out_valid;
    logic              out_ready;
    logic signed [3:0] q1;
    logic signed [3:0] q2;
    logic signed [3:0] q3;
    logic [8:0]        ctx;
    logic              sgn;

    modport master (
        output in_valid, d1, d2, d3, out_ready,
        input  in_ready, out_valid, q1, q2, q3, ctx, sgn
    );

    modport slave (
        input  in_valid, d1, d2, d3, out_ready,
        output in_ready, out_valid, q1, q2, q3, ctx, sgn
    );
endinterface

// File: rtl/grad_quant_ctx.sv
// LOCO-I gradient quantiser with programmable thresholds and NEAR,
// sign folding and merged context index; 2-stage valid/ready pipeline.
module grad_quant_ctx #(
    parameter int DW     = 8,
    parameter int T1_DEF = 3,
    parameter int T2_DEF = 7,
    parameter int T3_DEF = 21
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    grad_quant_ctx_if.slave bus,
    input  logic          cfg_we,
    input  logic [DW-1:0] cfg_t1,
    input  logic [DW-1:0] cfg_t2,
    input  logic [DW-1:0] cfg_t3,
    input  logic [DW-1:0] cfg_near,
    output logic          cfg_err
);

    logic [DW-1:0] t1, t2, t3, near;
    logic          cfg_ok;

    logic              s1_valid, s2_valid;
    logic              s1_load, s2_load;
    logic signed [3:0] s1_q1, s1_q2, s1_q3;
    logic signed [3:0] f1, f2, f3;
    logic              neg;
    logic signed [10:0] ctx_w;

    // T3 <= 2^DW-1 holds by construction of the DW-bit register
    assign cfg_ok = (cfg_near < cfg_t1) && (cfg_t1 <= cfg_t2) &&
                    (cfg_t2 <= cfg_t3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t1      <= DW'(T1_DEF);
            t2      <= DW'(T2_DEF);
            t3      <= DW'(T3_DEF);
            near    <= '0;
            cfg_err <= 1'b0;
        end else if (cfg_we) begin
            if (cfg_ok) begin
                t1      <= cfg_t1;
                t2      <= cfg_t2;
                t3      <= cfg_t3;
                near    <= cfg_near;
                cfg_err <= 1'b0;
            end else begin
                cfg_err <= 1'b1;
            end
        end
    end

    function automatic logic signed [3:0] quant(input logic signed [DW:0] d);
        logic signed [DW+1:0] x, p1, p2, p3, pn;
        x  = {d[DW], d};
        p1 = {2'b00, t1};
        p2 = {2'b00, t2};
        p3 = {2'b00, t3};
        pn = {2'b00, near};
        if (x <= -p3)      quant = -4'sd4;
        else if (x <= -p2) quant = -4'sd3;
        else if (x <= -p1) quant = -4'sd2;
        else if (x < -pn)  quant = -4'sd1;
        else if (x <= pn)  quant = 4'sd0;
        else if (x < p1)   quant = 4'sd1;
        else if (x < p2)   quant = 4'sd2;
        else if (x < p3)   quant = 4'sd3;
        else               quant = 4'sd4;
    endfunction

    assign s2_load       = !s2_valid || bus.out_ready;
    assign s1_load       = !s1_valid || s2_load;
    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s2_valid;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (clr) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_load) s1_valid <= bus.in_valid;
            if (s2_load) s2_valid <= s1_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q1 <= '0;
            s1_q2 <= '0;
            s1_q3 <= '0;
        end else if (s1_load && bus.in_valid) begin
            s1_q1 <= quant(bus.d1);
            s1_q2 <= quant(bus.d2);
            s1_q3 <= quant(bus.d3);
        end
    end

    // negate when the first nonzero element is negative
    always_comb begin
        neg = (s1_q1 < 0) ||
              (s1_q1 == 0 && ((s1_q2 < 0) || (s1_q2 == 0 && s1_q3 < 0)));
        f1  = neg ? -s1_q1 : s1_q1;
        f2  = neg ? -s1_q2 : s1_q2;
        f3  = neg ? -s1_q3 : s1_q3;
        ctx_w = 11'sd81 * 11'(f1) + 11'sd9 * 11'(f2) + 11'(f3);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.q1  <= '0;
            bus.q2  <= '0;
            bus.q3  <= '0;
            bus.ctx <= '0;
            bus.sgn <= 1'b0;
        end else if (s2_load && s1_valid) begin
            bus.q1  <= f1;
            bus.q2  <= f2;
            bus.q3  <= f3;
            bus.ctx <= ctx_w[8:0];
            bus.sgn <= neg;
        end
    end

endmodule

// File: tb/tb_grad_quant_ctx.sv
// Randomised and directed bench for grad_quant_ctx against a
// queue-based behavioural model.
module tb_grad_quant_ctx;

    typedef struct {
        int q1;
        int q2;
        int q3;
        int ctx;
        int sgn;
    } res_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       cfg_we = 1'b0;
    logic [7:0] cfg_t1 = 8'd0;
    logic [7:0] cfg_t2 = 8'd0;
    logic [7:0] cfg_t3 = 8'd0;
    logic [7:0] cfg_near = 8'd0;
    logic       cfg_err;

    grad_quant_ctx_if #(.DW(8)) bus ();

    grad_quant_ctx #(.DW(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .bus      (bus),
        .cfg_we   (cfg_we),
        .cfg_t1   (cfg_t1),
        .cfg_t2   (cfg_t2),
        .cfg_t3   (cfg_t3),
        .cfg_near (cfg_near),
        .cfg_err  (cfg_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    res_t exp_q[$];
    int mt1 = 3, mt2 = 7, mt3 = 21, mnear = 0, merr = 0;
    int pops = 0;
    int rdy_mode = 0;
    int pat_idx = 0;
    bit pat[8] = '{1, 0, 0, 1, 0, 1, 1, 1};

    task automatic chk(string nm, int act, int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic int mq(int d);
        if (d <= -mt3)       return -4;
        else if (d <= -mt2)  return -3;
        else if (d <= -mt1)  return -2;
        else if (d < -mnear) return -1;
        else if (d <= mnear) return 0;
        else if (d < mt1)    return 1;
        else if (d < mt2)    return 2;
        else if (d < mt3)    return 3;
        return 4;
    endfunction

    function automatic res_t model(int a, int b, int c);
        res_t r;
        int v[3];
        int s;
        v[0] = mq(a); v[1] = mq(b); v[2] = mq(c);
        s = 0;
        for (int i = 2; i >= 0; i--) if (v[i] != 0) s = (v[i] < 0);
        if (s == 1) for (int i = 0; i < 3; i++) v[i] = -v[i];
        r.q1 = v[0]; r.q2 = v[1]; r.q3 = v[2];
        r.ctx = 81 * v[0] + 9 * v[1] + v[2];
        r.sgn = s;
        return r;
    endfunction

    function automatic res_t dut_res();
        res_t r;
        r.q1 = int'(bus.q1); r.q2 = int'(bus.q2); r.q3 = int'(bus.q3);
        r.ctx = int'(bus.ctx); r.sgn = int'(bus.sgn);
        return r;
    endfunction

    function automatic int pack(res_t r);
        return ((r.q1 & 15) << 14) | ((r.q2 & 15) << 10) |
               ((r.q3 & 15) << 6) | (r.sgn << 5) | (r.ctx & 0);
    endfunction

    task automatic chk_res(string nm, res_t a, res_t e);
        checks++;
        if (a == e) passes++;
        else $display("FAIL %s: got q=(%0d,%0d,%0d) ctx=%0d sgn=%0d expected q=(%0d,%0d,%0d) ctx=%0d sgn=%0d",
                      nm, a.q1, a.q2, a.q3, a.ctx, a.sgn,
                      e.q1, e.q2, e.q3, e.ctx, e.sgn);
    endtask

    // model update: accepted samples are quantised with pre-edge config
    always @(negedge reset) begin
        exp_q.delete();
        mt1 = 3; mt2 = 7; mt3 = 21; mnear = 0; merr = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                void'(exp_q.pop_front());
                pops++;
            end
            if (clr) exp_q.delete();
            else if (bus.in_valid && bus.in_ready)
                exp_q.push_back(model(int'(bus.d1), int'(bus.d2), int'(bus.d3)));
            if (cfg_we) begin
                if (int'(cfg_near) < int'(cfg_t1) && cfg_t1 <= cfg_t2 &&
                    cfg_t2 <= cfg_t3) begin
                    mt1 = int'(cfg_t1); mt2 = int'(cfg_t2);
                    mt3 = int'(cfg_t3); mnear = int'(cfg_near); merr = 0;
                end else merr = 1;
            end
        end
    end

    res_t prev;
    bit   prev_stall = 0;

    always @(negedge clk) begin
        if (!reset) prev_stall = 0;
        else begin
            chk("cfg_err", int'(cfg_err), merr);
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                else chk_res("stream", dut_res(), exp_q[0]);
                if (prev_stall) chk_res("stall_stable", dut_res(), prev);
            end
            prev = dut_res();
            prev_stall = bus.out_valid && !bus.out_ready;
        end
    end

    task automatic push(int a, int b, int c);
        bit ok = 0;
        bus.d1 = 9'(a); bus.d2 = 9'(b); bus.d3 = 9'(c);
        bus.in_valid = 1'b1;
        for (int n = 0; n < 60 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
            @(posedge clk); #1;
            if (rdy_mode == 1) bus.out_ready = ($urandom % 3) != 0;
            else if (rdy_mode == 2) begin
                bus.out_ready = pat[pat_idx % 8];
                pat_idx++;
            end
        end
        bus.in_valid = 1'b0;
        if (!ok) chk("push_timeout", 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", int'(n >= 40), 0);
    endtask

    task automatic send_check(int a, int b, int c, int e1, int e2, int e3,
                              int ectx, int esgn);
        res_t e;
        bit got = 0;
        rdy_mode = 0;
        bus.out_ready = 1'b1;
        push(a, b, c);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = bus.out_valid;
        end
        e.q1 = e1; e.q2 = e2; e.q3 = e3; e.ctx = ectx; e.sgn = esgn;
        if (got) chk_res("literal", dut_res(), e);
        else chk("literal_timeout", 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic write_cfg(int a, int b, int c, int nr);
        cfg_t1 = 8'(a); cfg_t2 = 8'(b); cfg_t3 = 8'(c); cfg_near = 8'(nr);
        cfg_we = 1'b1;
        @(posedge clk); #1;
        cfg_we = 1'b0;
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        bus.d1 = '0; bus.d2 = '0; bus.d3 = '0;
        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_ctx", int'(bus.ctx), 0);
        chk("rst_q1", int'(bus.q1), 0);
        chk("rst_sgn", int'(bus.sgn), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // defaults, literal table points
        send_check(2, 0, 0, 1, 0, 0, 81, 0);
        send_check(3, 0, 0, 2, 0, 0, 162, 0);
        send_check(20, 0, 0, 3, 0, 0, 243, 0);
        send_check(21, 0, 0, 4, 0, 0, 324, 0);
        send_check(-21, 0, 0, 4, 0, 0, 324, 1);
        send_check(-5, 3, 0, 2, -2, 0, 144, 1);
        send_check(0, 0, -1, 0, 0, 1, 1, 1);
        send_check(0, 0, 0, 0, 0, 0, 0, 0);

        // full sweep with random companions and random backpressure
        rdy_mode = 1;
        for (int d = -256; d <= 255; d++)
            push(d, int'($urandom_range(0, 510)) - 255,
                 int'($urandom_range(0, 510)) - 255);
        drain();

        // programmed thresholds and NEAR
        write_cfg(5, 10, 30, 2);
        send_check(2, 0, 0, 0, 0, 0, 0, 0);
        send_check(3, 0, 0, 1, 0, 0, 81, 0);
        send_check(-3, 0, 0, 1, 0, 0, 81, 1);
        write_cfg(4, 3, 30, 2);
        chk("cfg_reject", int'(cfg_err), 1);
        send_check(9, 0, 0, 2, 0, 0, 162, 0);

        // eight samples under a fixed ready pattern
        pops = 0;
        pat_idx = 0;
        rdy_mode = 2;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++)
            push(int'($urandom_range(0, 510)) - 255, i * 7 - 20, -i);
        rdy_mode = 0;
        drain();
        chk("delivered", pops, 8);

        // full and stalled pipeline, then flush
        bus.out_ready = 1'b0;
        push(40, -3, 1);
        push(-40, 2, 9);
        @(negedge clk);
        chk("full_in_ready", int'(bus.in_ready), 0);
        chk("full_out_valid", int'(bus.out_valid), 1);
        @(posedge clk); #1;
        clr = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("clr_out_valid", int'(bus.out_valid), 0);
        chk("clr_in_ready", int'(bus.in_ready), 1);
        @(posedge clk); #1;

        // reset mid-stream restores default config
        push(7, 7, 7);
        push(-7, 1, 1);
        #2;
        reset = 1'b0;
        #2;
        chk("mid_rst_out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_cfg_err", int'(cfg_err), 0);
        send_check(3, 0, 0, 2, 0, 0, 162, 0);
        send_check(-7, 0, 0, 3, 0, 0, 243, 1);

        rdy_mode = 1;
        for (int i = 0; i < 60; i++)
            push(int'($urandom_range(0, 510)) - 255,
                 int'($urandom_range(0, 510)) - 255,
                 int'($urandom_range(0, 510)) - 255);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
